// File: rtl/lut_cfg_pkg.sv
// Shared types for the LUT configuration loader.
// ST_PARITY exists only when LUT_CFG_PARITY_EN is defined.
package lut_cfg_pkg;

    localparam int unsigned MASK_W = 8;

    typedef logic [MASK_W-1:0] mask_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
`ifdef LUT_CFG_PARITY_EN
        ST_PARITY = 3'd2,
`endif
        ST_COMMIT = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/lut_cfg_shadow.sv
// Shadow bank of LUT masks, written one bit per cycle while a frame streams in.
module lut_cfg_shadow
    import lut_cfg_pkg::*;
#(
    parameter int unsigned NUM_LUTS  = 4,
    parameter int unsigned LUT_IDX_W = 2
)
(
    input  logic                         clk,
    input  logic                         we,
    input  logic [LUT_IDX_W-1:0]         lut_idx,
    input  logic [2:0]                   bit_idx,
    input  logic                         bit_val,
    output logic [NUM_LUTS*MASK_W-1:0]   shadow
);

    // Deliberately unreset: only a complete frame is ever copied out of here.
    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        mask_t bank;

        always_ff @(posedge clk) begin
            if (we && (lut_idx == LUT_IDX_W'(i))) begin
                bank[bit_idx] <= bit_val;
            end
        end

        assign shadow[i*MASK_W +: MASK_W] = bank;
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Bit-serial LUT mask loader with atomic commit of a complete frame.
// Optional per-mask even parity check enabled by defining LUT_CFG_PARITY_EN.
module lut_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int unsigned NUM_LUTS = 4
)
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_start,
    input  logic                         cfg_valid,
    input  logic                         cfg_bit,
    output logic                         cfg_ready,
    output logic [NUM_LUTS*MASK_W-1:0]   mask_out,
    output logic                         busy,
    output logic                         cfg_done,
    output logic                         cfg_err
);

    localparam int unsigned LUT_IDX_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam int unsigned BANK_W    = NUM_LUTS * MASK_W;
    localparam logic [LUT_IDX_W-1:0] LAST_LUT = LUT_IDX_W'(NUM_LUTS - 1);

    state_t                 state, state_nxt;
    logic [2:0]             bit_cnt, bit_cnt_nxt;
    logic [LUT_IDX_W-1:0]   lut_cnt, lut_cnt_nxt;
    logic                   shadow_we;
    logic                   commit;
    logic                   xfer;
    logic                   last_lut;
    logic                   ready_nxt;
    logic                   busy_nxt;
    logic [BANK_W-1:0]      shadow;

    assign xfer     = cfg_valid & cfg_ready;
    assign last_lut = (lut_cnt == LAST_LUT);

`ifdef LUT_CFG_PARITY_EN
    mask_t cur_mask;
    logic  parity_bad;

    assign cur_mask   = shadow[lut_cnt*MASK_W +: MASK_W];
    assign parity_bad = (^cur_mask) ^ cfg_bit;
    assign ready_nxt  = (state_nxt == ST_SHIFT) || (state_nxt == ST_PARITY);
`else
    assign ready_nxt  = (state_nxt == ST_SHIFT);
`endif
    assign busy_nxt   = ready_nxt || (state_nxt == ST_COMMIT);

    lut_cfg_shadow #(
        .NUM_LUTS  (NUM_LUTS),
        .LUT_IDX_W (LUT_IDX_W)
    ) u_shadow (
        .clk     (clk),
        .we      (shadow_we),
        .lut_idx (lut_cnt),
        .bit_idx (~bit_cnt),
        .bit_val (cfg_bit),
        .shadow  (shadow)
    );

    // Next-state, counter and strobe logic; cfg_start overrides everything.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        lut_cnt_nxt = lut_cnt;
        shadow_we   = 1'b0;
        commit      = 1'b0;

        if (cfg_start) begin
            state_nxt   = ST_SHIFT;
            bit_cnt_nxt = 3'd0;
            lut_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_SHIFT: begin
                    if (xfer) begin
                        shadow_we   = 1'b1;
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef LUT_CFG_PARITY_EN
                            state_nxt = ST_PARITY;
`else
                            if (last_lut) begin
                                state_nxt = ST_COMMIT;
                            end else begin
                                lut_cnt_nxt = lut_cnt + LUT_IDX_W'(1);
                            end
`endif
                        end
                    end
                end
`ifdef LUT_CFG_PARITY_EN
                ST_PARITY: begin
                    if (xfer) begin
                        if (parity_bad) begin
                            state_nxt = ST_ERR;
                        end else if (last_lut) begin
                            state_nxt = ST_COMMIT;
                        end else begin
                            state_nxt   = ST_SHIFT;
                            lut_cnt_nxt = lut_cnt + LUT_IDX_W'(1);
                        end
                    end
                end
`endif
                ST_COMMIT: begin
                    state_nxt = ST_IDLE;
                    commit    = 1'b1;
                end
                ST_ERR: begin
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            lut_cnt   <= '0;
            mask_out  <= '0;
            cfg_ready <= 1'b0;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            lut_cnt   <= lut_cnt_nxt;
            cfg_ready <= ready_nxt;
            busy      <= busy_nxt;
            cfg_done  <= commit;
            if (commit) begin
                mask_out <= shadow;
            end
        end
    end

`ifdef LUT_CFG_PARITY_EN
    // Error flag tracks the ERR state; cfg_start leaves ERR, which clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (state_nxt == ST_ERR);
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed bench for lut_cfg_loader with NUM_LUTS=2; parity cases run when LUT_CFG_PARITY_EN is defined.
module tb_lut_cfg_loader;

    logic        clk;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_valid;
    logic        cfg_bit;
    logic        cfg_ready;
    logic [15:0] mask_out;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    lut_cfg_loader #(.NUM_LUTS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .mask_out  (mask_out),
        .busy      (busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef LUT_CFG_PARITY_EN
        send_bit(^b);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (mask_out !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h expected %h", mask_out, 16'h0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b1;
            tick();
            checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", cfg_ready); end
            checks++; if (mask_out !== 16'h0000) begin errors++; $display("FAIL idle_mask: got %h expected %h", mask_out, 16'h0000); end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_start();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %b expected 1", cfg_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
        send_byte(8'hE8);
        send_byte(8'h96);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL commit_ready: got %b expected 0", cfg_ready); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL commit_early_done: got %b expected 0", cfg_done); end
        checks++; if (mask_out !== 16'h0000) begin errors++; $display("FAIL commit_early_mask: got %h expected %h", mask_out, 16'h0000); end
        tick();
        checks++; if (mask_out !== 16'h96E8) begin errors++; $display("FAIL basic_mask: got %h expected %h", mask_out, 16'h96E8); end
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", cfg_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", busy); end
        tick();
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", cfg_done); end
    endtask

    task automatic test_stall();
        logic [17:0] stream;
        int nbits;
`ifdef LUT_CFG_PARITY_EN
        stream = {8'hE8, 1'b0, 8'h96, 1'b0};
        nbits  = 18;
`else
        stream = {2'b00, 8'hE8, 8'h96};
        nbits  = 16;
`endif
        do_reset();
        do_start();
        for (int k = nbits - 1; k >= 0; k--) begin
            if (k != nbits - 1) begin
                for (int g = 0; g < 2; g++) begin
                    cfg_valid = 1'b0;
                    cfg_bit   = ~stream[k];
                    tick();
                    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stall_ready: got %b expected 1", cfg_ready); end
                end
            end
            send_bit(stream[k]);
        end
        tick();
        checks++; if (mask_out !== 16'h96E8) begin errors++; $display("FAIL stall_mask: got %h expected %h", mask_out, 16'h96E8); end
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b expected 1", cfg_done); end
        tick();
    endtask

    task automatic test_restart();
        do_start();
        send_byte(8'hFF);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        do_start();
        cfg_valid = 1'b0;
        checks++; if (mask_out !== 16'h96E8) begin errors++; $display("FAIL restart_hold: got %h expected %h", mask_out, 16'h96E8); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b expected 1", cfg_ready); end
        send_byte(8'h01);
        send_byte(8'h02);
        checks++; if (mask_out !== 16'h96E8) begin errors++; $display("FAIL restart_precommit: got %h expected %h", mask_out, 16'h96E8); end
        tick();
        checks++; if (mask_out !== 16'h0201) begin errors++; $display("FAIL restart_mask: got %h expected %h", mask_out, 16'h0201); end
        checks++; if (cfg_done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b expected 1", cfg_done); end
        tick();
    endtask

    task automatic test_reset_midframe();
        do_start();
        send_byte(8'hCD);
        send_byte(8'hAB);
        tick();
        checks++; if (mask_out !== 16'hABCD) begin errors++; $display("FAIL prior_mask: got %h expected %h", mask_out, 16'hABCD); end
        do_start();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        do_reset();
        checks++; if (mask_out !== 16'h0000) begin errors++; $display("FAIL midrst_mask: got %h expected %h", mask_out, 16'h0000); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", cfg_ready); end
        for (int i = 0; i < 20; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = i[0];
            tick();
            checks++; if (cfg_ready !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL midrst_ignore: got ready=%b done=%b expected 0 0", cfg_ready, cfg_done); end
        end
        cfg_valid = 1'b0;
        checks++; if (mask_out !== 16'h0000) begin errors++; $display("FAIL midrst_after: got %h expected %h", mask_out, 16'h0000); end
    endtask

    task automatic test_parity();
`ifdef LUT_CFG_PARITY_EN
        logic [7:0] m;
        m = 8'hE8;
        do_start();
        for (int i = 7; i >= 0; i--) send_bit(m[i]);
        send_bit(1'b1);
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL parity_err: got %b expected 1", cfg_err); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL parity_ready: got %b expected 0", cfg_ready); end
        checks++; if (mask_out !== 16'h0000) begin errors++; $display("FAIL parity_mask: got %h expected %h", mask_out, 16'h0000); end
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1; cfg_bit = 1'b0;
            tick();
            checks++; if (cfg_done !== 1'b0 || cfg_err !== 1'b1) begin errors++; $display("FAIL parity_hold: got done=%b err=%b expected 0 1", cfg_done, cfg_err); end
        end
        cfg_valid = 1'b0;
        do_start();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b expected 0", cfg_err); end
        send_byte(8'hE8);
        send_byte(8'h96);
        tick();
        checks++; if (mask_out !== 16'h96E8) begin errors++; $display("FAIL parity_good_mask: got %h expected %h", mask_out, 16'h96E8); end
        tick();
`else
        do_start();
        send_byte(8'h3C);
        send_byte(8'h5A);
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL noparity_err: got %b expected 0", cfg_err); end
        tick();
        checks++; if (mask_out !== 16'h5A3C) begin errors++; $display("FAIL noparity_mask: got %h expected %h", mask_out, 16'h5A3C); end
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_restart();
        test_reset_midframe();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_cfg_loader.md
# lut_cfg_loader

Serial configuration writer for the fabric's 3-input LUTs: accepts a bit-serial configuration stream over a valid/ready handshake and assembles it into a shadow bank of 8-bit LUT masks. It commits all masks to the LUT mask inputs atomically, only after a complete and valid frame. It sits between the external configuration port and the array of LUT instances, and is the only block that drives LUT masks.

## Interface
- NUM_LUTS, default 4: number of LUTs programmed per frame (≥1).
- MASK_W, default 8: mask bits per LUT. Fixed at 8 by the 3-input LUT; not overridable in practice.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse that begins (or restarts) a frame.
- cfg_valid  in  1  cfg_bit is valid this cycle.
- cfg_bit  in  1  configuration data bit.
- cfg_ready  out  1  loader accepts a bit this cycle; a transfer occurs when cfg_valid & cfg_ready.
- mask_out  out  NUM_LUTS*MASK_W  committed masks; LUT i, mask bit j at index i*MASK_W+j.
- busy  out  1  frame in progress (SHIFT, PARITY or COMMIT).
- cfg_done  out  1  one-cycle pulse when mask_out takes new values.
- cfg_err  out  1  sticky frame error; cleared by cfg_start or reset.

## Operation
- States: IDLE, SHIFT, PARITY (only when the macro is defined), COMMIT, ERR.
- IDLE: cfg_ready=0. On cfg_start, go to SHIFT and clear bit_cnt, lut_cnt and cfg_err.
- SHIFT: cfg_ready=1. Each transfer writes cfg_bit into shadow[lut_cnt][7-bit_cnt], so each LUT is sent MSB first. LUT 0 is sent first.
- End of a mask (bit_cnt==7):
  - Macro defined: go to PARITY.
  - Macro not defined, last LUT: go to COMMIT.
  - Macro not defined, otherwise: increment lut_cnt, reset bit_cnt, stay in SHIFT.
- COMMIT: cfg_ready=0. On the next edge, mask_out <= shadow, cfg_done=1 for that cycle, go to IDLE.
- ERR: cfg_ready=0, cfg_err=1, mask_out unchanged. Leave only on cfg_start, which goes to SHIFT.
- cfg_start while busy aborts the current frame and restarts it in SHIFT. The shadow bank is overwritten progressively and mask_out is untouched. If cfg_start and a transfer occur in the same cycle, cfg_start wins and the bit is dropped.
- cfg_valid without cfg_ready is ignored. Bits outside a frame are discarded.
- mask_out changes only in the COMMIT→IDLE transition. Partial frames never reach the LUTs.

## Timing
- Reset values: state=IDLE, mask_out=0, busy=0, cfg_ready=0, cfg_done=0, cfg_err=0, all counters 0. The shadow bank is not reset.
- Reset asserted mid-frame returns to IDLE with mask_out=0 at the next edge.
- cfg_start sampled at edge k: cfg_ready=1 and busy=1 from cycle k+1.
- Last bit accepted at edge k: COMMIT in cycle k+1, cfg_ready=0. mask_out is new and cfg_done=1 in cycle k+2 (same cycle), and busy=0 in cycle k+2.
- Minimum frame length, no stalls: 1 + NUM_LUTS*8 (+NUM_LUTS with parity) + 1 cycles.
- Counters: bit_cnt is 3 bits and wraps 7→0. lut_cnt is $clog2(NUM_LUTS) bits (minimum 1). No increment occurs past NUM_LUTS-1.

## Configuration
- LUT_CFG_PARITY_EN defined: after each 8-bit mask, one extra bit is accepted in PARITY. Even parity is required: XOR of the 8 mask bits and the parity bit must be 0.
  - Match: continue to SHIFT for the next LUT, or to COMMIT after the last LUT.
  - Mismatch: go to ERR at the next edge.
- LUT_CFG_PARITY_EN undefined: the PARITY state and its logic are absent. cfg_err can never assert and is tied 0.

## Structure
- Package lut_cfg_pkg holds:
  - the state enum type;
  - localparam MASK_W=8;
  - a mask_t typedef (logic [MASK_W-1:0]).
- One sub-module, lut_cfg_shadow, holds the shadow bank:
  - inputs: write-enable, lut index, bit index, bit value;
  - output: the flattened shadow vector.
- Top-level lut_cfg_loader holds the FSM, counters, parity check and the mask_out commit register.

## Test plan
- NUM_LUTS=2, no parity. Start, then stream 0xE8 followed by 0x96, MSB first, no stalls → mask_out=16'h96E8, single cfg_done pulse 2 cycles after the last bit.
- Same stream with cfg_valid toggling 1,0,0,1… → identical result. No bit is accepted while cfg_valid=0, and cfg_ready stays 1 throughout SHIFT.
- Stream 0xFF plus 4 bits, then cfg_start, then a full 0x01,0x02 frame → mask_out stays at its prior value until commit, then becomes 16'h0201.
- Drive rst_n=0 for one cycle mid-frame after a prior commit of 16'hABCD → mask_out=0, IDLE, busy=0. Subsequent bits are ignored until cfg_start.
- LUT_CFG_PARITY_EN defined, mask 0xE8 sent with parity bit 1 (wrong; even parity needs 0) → cfg_err=1, cfg_ready=0, mask_out unchanged, no cfg_done. The next cfg_start clears cfg_err.
- Reset with no frame → all outputs 0. cfg_valid=1 pulses in IDLE → cfg_ready stays 0 and mask_out stays 0.
